// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. It walks a one-cold anode strobe across DIGITS digits and presents
// the matching nibble on hexVal for a downstream hex-to-cathode decoder. Each
// digit slot begins with GUARD clocks of dead time (all anodes off) to
// suppress ghosting. The 32-bit display word is double-buffered and reloads
// only at frame boundaries, so a frame never tears.
//
// Optional feature macro: LEAD_ZERO_BLANK_EN
//   defined   : digit k>0 is blanked when shadow nibbles k..DIGITS-1 are all
//               zero; digit 0 is never blanked. hexVal, the scan timing and
//               frame_done do not change.
//   undefined : every digit is lit in its slot, leading zeros included.
//
// Parameter limits: DIGITS 2..8, REFRESH_DIV >= 2, GUARD < REFRESH_DIV.
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] data,
  output logic [7:0]  anode,
  output logic [3:0]  hexVal,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  // Slot counter width; REFRESH_DIV=2 still needs one bit.
  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_MAX = 3'(DIGITS - 1);
  localparam logic [31:0]      GUARD_U = 32'(GUARD);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [31:0]      r_shadow;
  logic             r_load_pend;
  logic             r_frame_done;

  logic             w_slot_end;
  logic             w_wrap;
  logic             w_in_guard;
  logic             w_blank;

  // Last clock of a slot, and last clock of the last slot (frame wrap).
  assign w_slot_end = (r_cnt == CNT_MAX);
  assign w_wrap     = w_slot_end && (r_idx == IDX_MAX);
  assign w_in_guard = (32'(r_cnt) < GUARD_U);

  // Scan state: reset beats enable, and a disabled scan freezes in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_load_pend  <= 1'b1;
      r_frame_done <= 1'b0;
    end else if (enable) begin
      r_frame_done <= w_wrap;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_MAX) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // First enabled edge after reset, or a frame wrap, samples data.
      if (r_load_pend || w_wrap) begin
        r_shadow <= data;
      end
      r_load_pend <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
    end
  end

  // Nibble of the current slot, shown even during guard time.
  always_comb begin
    hexVal = 4'h0;
    for (int k = 0; k < 8; k++) begin
      if (r_idx == 3'(k)) begin
        hexVal = r_shadow[4*k +: 4];
      end
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // Only the nibbles of real digits take part in leading-zero detection.
  localparam logic [31:0] DIGIT_MASK =
    (DIGITS >= 8) ? 32'hFFFF_FFFF : 32'((64'd1 << (4 * DIGITS)) - 64'd1);

  // Blank digit k>0 when it and every more significant digit are zero.
  always_comb begin
    w_blank = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (r_idx == 3'(k)) begin
        w_blank = (((r_shadow & DIGIT_MASK) >> (4 * k)) == 32'd0);
      end
    end
  end
`else
  // Leading zeros are displayed like any other digit.
  always_comb begin
    w_blank = 1'b0;
  end
`endif

  // Active-low strobe: dark when frozen, in guard time, or blanked.
  always_comb begin
    anode = 8'hFF;
    if (enable && !w_in_guard && !w_blank) begin
      anode = ~(8'b1 << r_idx);
    end
  end

  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with DIGITS=8, REFRESH_DIV=4, GUARD=1,
// plus a second small instance (DIGITS=3, REFRESH_DIV=2, GUARD=0) sharing
// the same inputs to cover the narrow-configuration corner.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int RD = 4;

  // Clock / reset / stimulus
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] data;

  logic [7:0]  anode;
  logic [3:0]  hexVal;
  logic [2:0]  digit_idx;
  logic        frame_done;

  logic [7:0]  s_anode;
  logic [3:0]  s_hex;
  logic [2:0]  s_idx;
  logic        s_fd;

  int errors = 0;
  int checks = 0;

  // Expected slot position (count, index) of the main instance.
  int ec;
  int ei;

  logic [3:0] tbl_1234abcd [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(8), .REFRESH_DIV(4), .GUARD(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data       (data),
    .anode      (anode),
    .hexVal     (hexVal),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  seg_scan_ctrl #(.DIGITS(3), .REFRESH_DIV(2), .GUARD(0)) u_small (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data       (data),
    .anode      (s_anode),
    .hexVal     (s_hex),
    .digit_idx  (s_idx),
    .frame_done (s_fd)
  );

  function automatic logic [7:0] lit(input int k);
    logic [7:0] v;
    v = 8'hFF;
    v[k] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] nib(input logic [31:0] w, input int k);
    return w[4*k +: 4];
  endfunction

  // One enabled clock of the main instance, sampled 1ns after the edge.
  task automatic advance();
    @(posedge clk);
    #1;
    if (ec == RD - 1) begin
      ec = 0;
      ei = (ei + 1) % 8;
    end else begin
      ec = ec + 1;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    data   = 32'h1234ABCD;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (anode !== 8'hFF) begin errors++; $display("FAIL reset_anode: got %h want ff", anode); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", digit_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    checks++; if (hexVal !== 4'h0) begin errors++; $display("FAIL reset_hex: got %h want 0", hexVal); end
    reset = 1'b0;
    ec = 0;
    ei = 0;
    #1;
    checks++; if (anode !== 8'hFF) begin errors++; $display("FAIL post_reset_guard: got %h want ff", anode); end
    advance();
    checks++; if (anode !== 8'hFE) begin errors++; $display("FAIL first_load_anode: got %h want fe", anode); end
    checks++; if (hexVal !== 4'hD) begin errors++; $display("FAIL first_load_hex: got %h want d", hexVal); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL first_load_fd: got %b want 0", frame_done); end
  endtask

  task automatic test_scan_walk();
    logic [7:0] exp_an;
    logic       exp_fd;
    int         pulses;
    pulses = 0;
    for (int n = 0; n < 31; n++) begin
      advance();
      exp_an = (ec < 1) ? 8'hFF : lit(ei);
      exp_fd = (ec == 0) && (ei == 0);
      if (frame_done === 1'b1) pulses++;
      checks++; if (anode !== exp_an) begin errors++; $display("FAIL walk_anode n=%0d: got %h want %h", n, anode, exp_an); end
      checks++; if (hexVal !== tbl_1234abcd[ei]) begin errors++; $display("FAIL walk_hex n=%0d: got %h want %h", n, hexVal, tbl_1234abcd[ei]); end
      checks++; if (digit_idx !== 3'(ei)) begin errors++; $display("FAIL walk_idx n=%0d: got %0d want %0d", n, digit_idx, ei); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL walk_fd n=%0d: got %b want %b", n, frame_done, exp_fd); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL walk_pulse_count: got %0d want 1", pulses); end
  endtask

  // Starts at slot 0 of a new frame; data goes to zero during slot 3.
  task automatic test_tearing();
    logic [7:0] exp_an;
    logic [3:0] exp_hex;
    logic       exp_fd;
    for (int n = 0; n < 54; n++) begin
      advance();
      exp_an  = (ec < 1) ? 8'hFF : lit(ei);
      exp_hex = (n >= 31) ? 4'h0 : tbl_1234abcd[ei];
      exp_fd  = (n == 31);
      checks++; if (anode !== exp_an) begin errors++; $display("FAIL tear_anode n=%0d: got %h want %h", n, anode, exp_an); end
      checks++; if (hexVal !== exp_hex) begin errors++; $display("FAIL tear_hex n=%0d: got %h want %h", n, hexVal, exp_hex); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL tear_fd n=%0d: got %b want %b", n, frame_done, exp_fd); end
      if (n == 12) data = 32'h0000_0000;
    end
  endtask

  // Starts at count 2 of slot 5.
  task automatic test_enable_freeze();
    enable = 1'b0;
    #1;
    checks++; if (anode !== 8'hFF) begin errors++; $display("FAIL freeze_anode_comb: got %h want ff", anode); end
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      checks++; if (anode !== 8'hFF) begin errors++; $display("FAIL freeze_anode n=%0d: got %h want ff", n, anode); end
      checks++; if (digit_idx !== 3'd5) begin errors++; $display("FAIL freeze_idx n=%0d: got %0d want 5", n, digit_idx); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL freeze_fd n=%0d: got %b want 0", n, frame_done); end
    end
    enable = 1'b1;
    #1;
    checks++; if (anode !== 8'hDF) begin errors++; $display("FAIL resume_cnt2: got %h want df", anode); end
    advance();
    checks++; if (anode !== 8'hDF) begin errors++; $display("FAIL resume_cnt3: got %h want df", anode); end
    advance();
    checks++; if (anode !== 8'hFF) begin errors++; $display("FAIL resume_guard6: got %h want ff", anode); end
    checks++; if (digit_idx !== 3'd6) begin errors++; $display("FAIL resume_idx6: got %0d want 6", digit_idx); end
    advance();
    checks++; if (anode !== 8'hBF) begin errors++; $display("FAIL resume_lit6: got %h want bf", anode); end
  endtask

  // Starts in slot 6; a one-clock reset aborts the frame.
  task automatic test_reset_mid_scan();
    logic [7:0] exp_an;
    logic       exp_fd;
    data  = 32'h8765_4321;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (anode !== 8'hFF) begin errors++; $display("FAIL midrst_anode: got %h want ff", anode); end
    checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL midrst_idx: got %0d want 0", digit_idx); end
    checks++; if (hexVal !== 4'h0) begin errors++; $display("FAIL midrst_hex: got %h want 0", hexVal); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_fd: got %b want 0", frame_done); end
    reset = 1'b0;
    ec = 0;
    ei = 0;
    for (int n = 0; n < 33; n++) begin
      advance();
      exp_an = (ec < 1) ? 8'hFF : lit(ei);
      exp_fd = (n == 31);
      checks++; if (anode !== exp_an) begin errors++; $display("FAIL reload_anode n=%0d: got %h want %h", n, anode, exp_an); end
      checks++; if (hexVal !== nib(32'h8765_4321, ei)) begin errors++; $display("FAIL reload_hex n=%0d: got %h want %h", n, hexVal, nib(32'h8765_4321, ei)); end
      checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL reload_fd n=%0d: got %b want %b", n, frame_done, exp_fd); end
    end
  endtask

  // One frame per display word; expected anodes depend on blanking build.
  task automatic test_leading_zero();
    logic [7:0]  exp_an;
    logic [31:0] words [2];
    words[0] = 32'h0000_0042;
    words[1] = 32'h0000_0000;
    for (int w = 0; w < 2; w++) begin
      data  = words[w];
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      ec = 0;
      ei = 0;
      for (int n = 0; n < 32; n++) begin
        advance();
        if (ec < 1) begin
          exp_an = 8'hFF;
        end else begin
`ifdef LEAD_ZERO_BLANK_EN
          if (w == 0) exp_an = (ei <= 1) ? lit(ei) : 8'hFF;
          else        exp_an = (ei == 0) ? lit(ei) : 8'hFF;
`else
          exp_an = lit(ei);
`endif
        end
        checks++; if (anode !== exp_an) begin errors++; $display("FAIL lz_anode w=%0d n=%0d: got %h want %h", w, n, anode, exp_an); end
        checks++; if (hexVal !== nib(words[w], ei)) begin errors++; $display("FAIL lz_hex w=%0d n=%0d: got %h want %h", w, n, hexVal, nib(words[w], ei)); end
      end
    end
  endtask

  // Three-digit instance: upper anode bits stay high, wrap after digit 2.
  task automatic test_small_config();
    logic [7:0] exp_an  [6] = '{8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hFE};
    logic [3:0] exp_hex [6] = '{4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h1};
    logic [2:0] exp_idx [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0};
    logic       exp_fd  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    data  = 32'hFFFF_F321;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (s_anode !== 8'hFE) begin errors++; $display("FAIL small_first: got %h want fe", s_anode); end
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      checks++; if (s_anode !== exp_an[n]) begin errors++; $display("FAIL small_anode n=%0d: got %h want %h", n, s_anode, exp_an[n]); end
      checks++; if (s_hex !== exp_hex[n]) begin errors++; $display("FAIL small_hex n=%0d: got %h want %h", n, s_hex, exp_hex[n]); end
      checks++; if (s_idx !== exp_idx[n]) begin errors++; $display("FAIL small_idx n=%0d: got %0d want %0d", n, s_idx, exp_idx[n]); end
      checks++; if (s_fd !== exp_fd[n]) begin errors++; $display("FAIL small_fd n=%0d: got %b want %b", n, s_fd, exp_fd[n]); end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    data   = 32'h0;
    test_reset();
    test_scan_walk();
    test_tearing();
    test_enable_freeze();
    test_reset_mid_scan();
    test_leading_zero();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
